// File: rtl/temporal_encoder_3mod_pkg.sv
// rtl/temporal_encoder_3mod_pkg.sv - shared sizes, FSM encodings and helpers for the temporal encoder
// Build option: TEMPORAL_FLUSH_EN adds the history flush input to the top level.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif
`ifndef NGRAM_SIZE
`define NGRAM_SIZE 3
`endif

package temporal_encoder_3mod_pkg;

   localparam int HV_DIMENSION_DEF = `HV_DIMENSION;
   localparam int NGRAM_SIZE_DEF   = `NGRAM_SIZE;

   typedef enum logic [1:0] {
      FILL          = 2'd0,
      OUTPUT_STABLE = 2'd1,
      READY         = 2'd2
   } state_t;

   // Never returns less than 1 so a counter sized by it always has a bit.
   function automatic int ceil_log2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/temporal_encoder_3mod_if.sv
// rtl/temporal_encoder_3mod_if.sv - sample/N-gram handshake bundle for the three-modality encoder
// master drives samples and downstream ready; slave is the encoder.
interface temporal_encoder_3mod_if
   import temporal_encoder_3mod_pkg::*;
#(
   parameter int HV_DIMENSION = HV_DIMENSION_DEF
) ();

   logic                     ValidIn_SI;
   logic                     ReadyOut_SO;
   logic                     ValidOut_SO;
   logic                     ReadyIn_SI;
   logic [0:HV_DIMENSION-1]  HypervectorIn_mod1_DI;
   logic [0:HV_DIMENSION-1]  HypervectorIn_mod2_DI;
   logic [0:HV_DIMENSION-1]  HypervectorIn_mod3_DI;
   logic [0:HV_DIMENSION-1]  HypervectorOut_mod1_DO;
   logic [0:HV_DIMENSION-1]  HypervectorOut_mod2_DO;
   logic [0:HV_DIMENSION-1]  HypervectorOut_mod3_DO;

   modport master (
      output ValidIn_SI, ReadyIn_SI,
      output HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
      input  ReadyOut_SO, ValidOut_SO,
      input  HypervectorOut_mod1_DO, HypervectorOut_mod2_DO, HypervectorOut_mod3_DO
   );

   modport slave (
      input  ValidIn_SI, ReadyIn_SI,
      input  HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
      output ReadyOut_SO, ValidOut_SO,
      output HypervectorOut_mod1_DO, HypervectorOut_mod2_DO, HypervectorOut_mod3_DO
   );

endinterface

// File: rtl/temporal_encoder_3mod_mod.sv
// rtl/temporal_encoder_3mod_mod.sv - one modality: sample history, rotate/XOR N-gram tree, output register
// Shift and clear enables come from the shared FSM in the top level.
module temporal_encoder_mod
   import temporal_encoder_3mod_pkg::*;
#(
   parameter int HV_DIMENSION = HV_DIMENSION_DEF,
   parameter int NGRAM_SIZE   = NGRAM_SIZE_DEF
) (
   input  logic                    Clk_CI,
   input  logic                    Reset_RI,
   input  logic                    Clear_SI,
   input  logic                    Shift_SI,
   input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
   output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

   typedef logic [0:HV_DIMENSION-1] hv_t;

   hv_t History_DP [NGRAM_SIZE];
   hv_t History_DN [NGRAM_SIZE];
   hv_t Ngram_D;

   always_comb begin
      History_DN[0] = HypervectorIn_DI;
      for (int i = 1; i < NGRAM_SIZE; i++) begin
         History_DN[i] = History_DP[i-1];
      end
   end

   // Older samples get one more rotation per age step; the N-gram uses the
   // post-shift history so it can be captured on the same edge as the shift.
   always_comb begin
      hv_t rot;
      rot     = '0;
      Ngram_D = History_DN[0];
      for (int i = 1; i < NGRAM_SIZE; i++) begin
         rot = History_DN[i];
         for (int j = 0; j < i; j++) begin
            rot = {rot[HV_DIMENSION-1], rot[0:HV_DIMENSION-2]};
         end
         Ngram_D = Ngram_D ^ rot;
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (!Reset_RI) begin
         for (int i = 0; i < NGRAM_SIZE; i++) begin
            History_DP[i] <= '0;
         end
         HypervectorOut_DO <= '0;
      end else if (Clear_SI) begin
         for (int i = 0; i < NGRAM_SIZE; i++) begin
            History_DP[i] <= '0;
         end
      end else if (Shift_SI) begin
         for (int i = 0; i < NGRAM_SIZE; i++) begin
            History_DP[i] <= History_DN[i];
         end
         HypervectorOut_DO <= Ngram_D;
      end
   end

endmodule

// File: rtl/temporal_encoder_3mod.sv
// rtl/temporal_encoder_3mod.sv - three-modality N-gram temporal encoder with fill/output handshake FSM
// Build option: TEMPORAL_FLUSH_EN adds FlushIn_SI to clear history and restart the fill count.
module temporal_encoder_3mod
   import temporal_encoder_3mod_pkg::*;
#(
   parameter int HV_DIMENSION = HV_DIMENSION_DEF,
   parameter int NGRAM_SIZE   = NGRAM_SIZE_DEF
) (
   input  logic                   Clk_CI,
   input  logic                   Reset_RI,
   temporal_encoder_3mod_if.slave Bus_S
`ifdef TEMPORAL_FLUSH_EN
   ,
   input  logic                   FlushIn_SI
`endif
);

   localparam int             CNT_W     = ceil_log2(NGRAM_SIZE + 1);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(NGRAM_SIZE - 1);

   state_t           State_SP, State_SN;
   logic [CNT_W-1:0] FillCntr_SP, FillCntr_SN;
   logic             Flush_S;
   logic             Accept_S;
   logic             ReadyOut_S;

`ifdef TEMPORAL_FLUSH_EN
   assign Flush_S = FlushIn_SI;
`else
   assign Flush_S = 1'b0;
`endif

   assign Accept_S = Bus_S.ValidIn_SI && ReadyOut_S;

   always_ff @(posedge Clk_CI) begin
      if (!Reset_RI) begin
         State_SP    <= FILL;
         FillCntr_SP <= '0;
      end else begin
         State_SP    <= State_SN;
         FillCntr_SP <= FillCntr_SN;
      end
   end

   always_comb begin
      State_SN    = State_SP;
      FillCntr_SN = FillCntr_SP;
      if (Flush_S) begin
         State_SN    = FILL;
         FillCntr_SN = '0;
      end else begin
         case (State_SP)
            FILL: begin
               if (Accept_S) begin
                  if (FillCntr_SP == FILL_LAST) begin
                     State_SN = OUTPUT_STABLE;
                  end else begin
                     FillCntr_SN = FillCntr_SP + 1'b1;
                  end
               end
            end
            OUTPUT_STABLE: begin
               if (Bus_S.ReadyIn_SI) begin
                  State_SN = READY;
               end
            end
            READY: begin
               if (Accept_S) begin
                  State_SN = OUTPUT_STABLE;
               end
            end
            default: begin
               State_SN    = FILL;
               FillCntr_SN = '0;
            end
         endcase
      end
   end

   // A pending flush blocks acceptance so the flushed cycle's sample is dropped.
   always_comb begin
      ReadyOut_S        = ((State_SP == FILL) || (State_SP == READY)) && !Flush_S;
      Bus_S.ReadyOut_SO = ReadyOut_S;
      Bus_S.ValidOut_SO = (State_SP == OUTPUT_STABLE);
   end

   temporal_encoder_mod #(
      .HV_DIMENSION (HV_DIMENSION),
      .NGRAM_SIZE   (NGRAM_SIZE)
   ) i_mod1 (
      .Clk_CI            (Clk_CI),
      .Reset_RI          (Reset_RI),
      .Clear_SI          (Flush_S),
      .Shift_SI          (Accept_S),
      .HypervectorIn_DI  (Bus_S.HypervectorIn_mod1_DI),
      .HypervectorOut_DO (Bus_S.HypervectorOut_mod1_DO)
   );

   temporal_encoder_mod #(
      .HV_DIMENSION (HV_DIMENSION),
      .NGRAM_SIZE   (NGRAM_SIZE)
   ) i_mod2 (
      .Clk_CI            (Clk_CI),
      .Reset_RI          (Reset_RI),
      .Clear_SI          (Flush_S),
      .Shift_SI          (Accept_S),
      .HypervectorIn_DI  (Bus_S.HypervectorIn_mod2_DI),
      .HypervectorOut_DO (Bus_S.HypervectorOut_mod2_DO)
   );

   temporal_encoder_mod #(
      .HV_DIMENSION (HV_DIMENSION),
      .NGRAM_SIZE   (NGRAM_SIZE)
   ) i_mod3 (
      .Clk_CI            (Clk_CI),
      .Reset_RI          (Reset_RI),
      .Clear_SI          (Flush_S),
      .Shift_SI          (Accept_S),
      .HypervectorIn_DI  (Bus_S.HypervectorIn_mod3_DI),
      .HypervectorOut_DO (Bus_S.HypervectorOut_mod3_DO)
   );

endmodule

// File: tb/tb_temporal_encoder_3mod.sv
// tb/tb_temporal_encoder_3mod.sv - directed self-checking bench, HV_DIMENSION=8, NGRAM_SIZE=3
// Hex literals are written with bit 0 as the MSB to match the [0:N-1] vectors.
module tb_temporal_encoder_3mod;

   logic Clk_CI;
   logic Reset_RI;
`ifdef TEMPORAL_FLUSH_EN
   logic FlushIn_SI;
`endif
   int   checks;
   int   errors;

   temporal_encoder_3mod_if #(.HV_DIMENSION(8)) tif ();

   temporal_encoder_3mod #(
      .HV_DIMENSION (8),
      .NGRAM_SIZE   (3)
   ) dut (
      .Clk_CI   (Clk_CI),
      .Reset_RI (Reset_RI),
      .Bus_S    (tif)
`ifdef TEMPORAL_FLUSH_EN
      ,
      .FlushIn_SI (FlushIn_SI)
`endif
   );

   initial Clk_CI = 1'b0;
   always #5 Clk_CI = ~Clk_CI;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_CI);
      #1;
   endtask

   task automatic send(input logic [0:7] a, input logic [0:7] b, input logic [0:7] c);
      tif.HypervectorIn_mod1_DI = a;
      tif.HypervectorIn_mod2_DI = b;
      tif.HypervectorIn_mod3_DI = c;
      tif.ValidIn_SI            = 1'b1;
      tick();
      tif.ValidIn_SI            = 1'b0;
   endtask

   task automatic handshake();
      tif.ReadyIn_SI = 1'b1;
      tick();
      tif.ReadyIn_SI = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Reset_RI = 1'b0;
`ifdef TEMPORAL_FLUSH_EN
      FlushIn_SI = 1'b0;
`endif
      tif.ValidIn_SI = 1'b0;
      tif.ReadyIn_SI = 1'b0;
      tif.HypervectorIn_mod1_DI = '0;
      tif.HypervectorIn_mod2_DI = '0;
      tif.HypervectorIn_mod3_DI = '0;
      tick();
      Reset_RI = 1'b1;

      check("rst_ready", 32'(tif.ReadyOut_SO), 32'h1);
      check("rst_valid", 32'(tif.ValidOut_SO), 32'h0);
      check("rst_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h00);
      check("rst_out2", 32'(tif.HypervectorOut_mod2_DO), 32'h00);
      check("rst_out3", 32'(tif.HypervectorOut_mod3_DO), 32'h00);

      // Fill: first two samples produce nothing
      send(8'h01, 8'h10, 8'h80);
      check("fill1_valid", 32'(tif.ValidOut_SO), 32'h0);
      send(8'h02, 8'h20, 8'h01);
      check("fill2_valid", 32'(tif.ValidOut_SO), 32'h0);
      send(8'h04, 8'h40, 8'h02);
      check("first_valid", 32'(tif.ValidOut_SO), 32'h1);
      check("first_ready", 32'(tif.ReadyOut_SO), 32'h0);
      check("first_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h45);
      check("first_out2", 32'(tif.HypervectorOut_mod2_DO), 32'h54);
      check("first_out3", 32'(tif.HypervectorOut_mod3_DO), 32'hA2);

      handshake();
      check("hs_valid", 32'(tif.ValidOut_SO), 32'h0);
      check("hs_ready", 32'(tif.ReadyOut_SO), 32'h1);
      check("hs_hold_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h45);

      // Steady state with rotation wrap
      send(8'h00, 8'h00, 8'h00);
      check("steady_valid", 32'(tif.ValidOut_SO), 32'h1);
      check("steady_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h82);
      check("steady_out2", 32'(tif.HypervectorOut_mod2_DO), 32'h28);
      check("steady_out3", 32'(tif.HypervectorOut_mod3_DO), 32'h41);

      // Backpressure: ValidIn held high, inputs changing, must be ignored
      tif.ValidIn_SI = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tif.HypervectorIn_mod1_DI = 8'(i * 16 + 3);
         tif.HypervectorIn_mod2_DI = 8'hFF;
         tif.HypervectorIn_mod3_DI = 8'(i + 7);
         tick();
         check("bp_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h82);
         check("bp_ready", 32'(tif.ReadyOut_SO), 32'h0);
         check("bp_valid", 32'(tif.ValidOut_SO), 32'h1);
      end
      tif.ValidIn_SI = 1'b0;
      handshake();
      send(8'h08, 8'h00, 8'h00);
      check("post_bp_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h09);
      check("post_bp_out2", 32'(tif.HypervectorOut_mod2_DO), 32'h10);
      check("post_bp_out3", 32'(tif.HypervectorOut_mod3_DO), 32'h80);

      // Reset from OUTPUT_STABLE
      Reset_RI = 1'b0;
      tick();
      Reset_RI = 1'b1;
      check("rst2_valid", 32'(tif.ValidOut_SO), 32'h0);
      check("rst2_ready", 32'(tif.ReadyOut_SO), 32'h1);
      check("rst2_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h00);

      // Reset mid-fill
      send(8'h01, 8'h00, 8'h00);
      send(8'h02, 8'h00, 8'h00);
      check("midfill_valid", 32'(tif.ValidOut_SO), 32'h0);
      Reset_RI = 1'b0;
      tick();
      Reset_RI = 1'b1;
      check("rst3_valid", 32'(tif.ValidOut_SO), 32'h0);
      check("rst3_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h00);
      check("rst3_out2", 32'(tif.HypervectorOut_mod2_DO), 32'h00);
      check("rst3_out3", 32'(tif.HypervectorOut_mod3_DO), 32'h00);
      send(8'h10, 8'h00, 8'h00);
      check("refill1_valid", 32'(tif.ValidOut_SO), 32'h0);
      send(8'h20, 8'h00, 8'h00);
      check("refill2_valid", 32'(tif.ValidOut_SO), 32'h0);
      send(8'h40, 8'h00, 8'h00);
      check("refill3_valid", 32'(tif.ValidOut_SO), 32'h1);
      check("refill3_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h54);
      check("refill3_out2", 32'(tif.HypervectorOut_mod2_DO), 32'h00);

`ifdef TEMPORAL_FLUSH_EN
      // Flush wins over simultaneous ValidIn in OUTPUT_STABLE
      FlushIn_SI = 1'b1;
      tif.ValidIn_SI = 1'b1;
      tif.HypervectorIn_mod1_DI = 8'hFF;
      #1;
      check("flush_ready_low", 32'(tif.ReadyOut_SO), 32'h0);
      tick();
      FlushIn_SI = 1'b0;
      tif.ValidIn_SI = 1'b0;
      check("flush_valid", 32'(tif.ValidOut_SO), 32'h0);
      check("flush_keep_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h54);
      check("flush_ready", 32'(tif.ReadyOut_SO), 32'h1);
      send(8'h01, 8'h00, 8'h00);
      check("fl_fill1_valid", 32'(tif.ValidOut_SO), 32'h0);
      send(8'h02, 8'h00, 8'h00);
      check("fl_fill2_valid", 32'(tif.ValidOut_SO), 32'h0);
      send(8'h04, 8'h00, 8'h00);
      check("fl_fill3_valid", 32'(tif.ValidOut_SO), 32'h1);
      check("fl_fill3_out1", 32'(tif.HypervectorOut_mod1_DO), 32'h45);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
